// File: rtl/debug_controller.sv
// Debug controller: loads instruction words from a UART byte stream, runs or
// single-steps the pipeline, and dumps the cycle counter plus the register file
// as a 132-byte frame back over the UART transmitter.
module debug_controller #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  input  logic               i_end_program,
  input  logic [NB_DATA-1:0] i_dbg_reg_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_we_IF,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic               o_halt,
  output logic [NB_ADDR-1:0] o_dbg_reg_addr,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP      = 3'd3,
    ST_DUMP_REQ  = 3'd4,
    ST_DUMP_WAIT = 3'd5
  } state_t;

  localparam logic [7:0]         CMD_LOAD  = 8'h4C;
  localparam logic [7:0]         CMD_RUN   = 8'h43;
  localparam logic [7:0]         CMD_STEP  = 8'h53;
  localparam logic [7:0]         CMD_DUMP  = 8'h44;
  localparam logic [7:0]         LAST_BYTE = 8'd131;
  localparam logic [NB_DATA-1:0] CNT_ONE   = {{(NB_DATA-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0]   word_q, word_d;
  logic [NB_DATA-1:0]   word_asm;
  logic                 we_q, we_d;
  logic [NB_DATA-1:0]   instr_q, instr_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [7:0]           idx_q, idx_d;
  logic [NB_DATA-1:0]   cnt_q, cnt_d;
  logic                 halt;
  logic [7:0]           reg_sel;
  logic [7:0]           cur_byte;

  // Byte 'sel' of a word, least-significant byte is sel=0.
  function automatic logic [7:0] pick_byte(input logic [NB_DATA-1:0] w,
                                           input logic [1:0] sel);
    logic [NB_DATA-1:0] s;
    s = w >> {sel, 3'b000};
    return s[7:0];
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_d = ST_LOAD;
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: state_d = ST_DUMP_REQ;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      // Only the HALT word ends a load session.
      ST_LOAD:      if (i_rx_valid && byte_cnt_q == 2'd3 && word_asm == '1) state_d = ST_IDLE;
      ST_RUN:       if (i_end_program) state_d = ST_DUMP_REQ;
      ST_STEP:      state_d = ST_DUMP_REQ;
      ST_DUMP_REQ:  state_d = ST_DUMP_WAIT;
      ST_DUMP_WAIT: if (i_tx_done) state_d = (idx_q == LAST_BYTE) ? ST_IDLE : ST_DUMP_REQ;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: freeze control and register-select for the dump
  always_comb begin
    halt    = !(state_q == ST_RUN || state_q == ST_STEP);
    reg_sel = (idx_q - 8'd4) >> 2;
    o_halt  = halt;
    o_state = state_q;
    o_dbg_reg_addr = (idx_q < 8'd4) ? '0 : reg_sel[NB_ADDR-1:0];
  end

  // Datapath next values: word assembly, cycle counter, dump byte sequencing
  always_comb begin
    word_asm = word_q;
    word_asm[{byte_cnt_q, 3'b000} +: 8] = i_rx_data;
    cur_byte = (idx_q < 8'd4) ? pick_byte(cnt_q, idx_q[1:0])
                              : pick_byte(i_dbg_reg_data, idx_q[1:0]);
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    we_d       = 1'b0;
    instr_d    = instr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    if (!halt && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && i_rx_data == CMD_LOAD) begin
          cnt_d      = '0;
          byte_cnt_d = 2'd0;
        end
      end
      ST_LOAD: begin
        if (i_rx_valid) begin
          word_d     = word_asm;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            instr_d = word_asm;
          end
        end
      end
      ST_DUMP_REQ: begin
        tx_start_d = 1'b1;
        tx_data_d  = cur_byte;
      end
      ST_DUMP_WAIT: begin
        if (i_tx_done) idx_d = (idx_q == LAST_BYTE) ? 8'd0 : idx_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also drops any partial word or partial frame
  always_ff @(posedge clk) begin
    if (i_rst) begin
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      we_q       <= 1'b0;
      instr_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
      idx_q      <= 8'd0;
      cnt_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      we_q       <= we_d;
      instr_q    <= instr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_we_IF            = we_q;
  assign o_instruction_data = instr_q;
  assign o_tx_start         = tx_start_q;
  assign o_tx_data          = tx_data_q;

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: stimulus pushes expected instruction
// writes and dump bytes into queues; a monitor pops and compares them.
module tb_debug_controller;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_done = 1'b0;
  logic        i_end_program = 1'b0;
  logic [31:0] i_dbg_reg_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_we_IF;
  logic [31:0] o_instruction_data;
  logic        o_halt;
  logic [4:0]  o_dbg_reg_addr;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  debug_controller #(.NB_DATA(32), .NB_ADDR(5)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .i_end_program(i_end_program),
    .i_dbg_reg_data(i_dbg_reg_data), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_we_IF(o_we_IF), .o_instruction_data(o_instruction_data), .o_halt(o_halt),
    .o_dbg_reg_addr(o_dbg_reg_addr), .o_state(o_state)
  );

  // Register file model, read combinationally by the dump
  logic [31:0] regs [32];
  assign i_dbg_reg_data = regs[o_dbg_reg_addr];

  typedef struct { logic [7:0] data; logic [4:0] addr; } tx_t;
  logic [31:0] we_q [$];
  tx_t         tx_q [$];
  tx_t         cur_exp;
  logic        have_cur = 1'b0;

  int     tests = 0;
  int     fails = 0;
  int     halt_low = 0;
  int     tx_pulses = 0;
  longint model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT transactions against the scoreboard queues
  always @(negedge clk) begin
    if (!i_rst) begin
      if (!o_halt) halt_low++;
      if (o_we_IF) begin
        if (we_q.size() == 0) check("we_unexpected", o_we_IF, 0);
        else check("we_word", o_instruction_data, we_q.pop_front());
      end
      if (o_tx_start) begin
        tx_pulses++;
        if (tx_q.size() == 0) begin
          check("tx_unexpected", o_tx_start, 0);
          have_cur = 1'b0;
        end else begin
          cur_exp = tx_q.pop_front();
          have_cur = 1'b1;
          check("tx_byte", o_tx_data, cur_exp.data);
          check("tx_reg_addr", o_dbg_reg_addr, cur_exp.addr);
        end
      end else if (o_state == 3'd5 && have_cur) begin
        check("wait_hold_data", o_tx_data, cur_exp.data);
        check("wait_hold_addr", o_dbg_reg_addr, cur_exp.addr);
      end
    end
  end

  // Transmitter model: acknowledge each start after a random delay
  initial begin
    int d;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (o_tx_start && !i_rst) begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        i_tx_done = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    model_cnt = 0;
    we_q.delete();
    tx_q.delete();
    have_cur = 1'b0;
    check("rst_state", o_state, 0);
    check("rst_halt", o_halt, 1);
    check("rst_we", o_we_IF, 0);
    check("rst_tx_start", o_tx_start, 0);
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) we_q.push_back(w);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic load_session(input int nwords, input logic [31:0] first);
    logic [31:0] w;
    send_byte(8'h4C);
    model_cnt = 0;
    for (int i = 0; i < nwords; i++) begin
      w = (i == 0) ? first : $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h7FFF_FFFF;
      load_word(w);
    end
    load_word(32'hFFFF_FFFF);
    @(negedge clk);
    check("load_done_state", o_state, 0);
    check("load_writes_left", we_q.size(), 0);
  endtask

  // Expected frame: counter then 32 registers, each word least-significant byte first
  task automatic push_frame();
    tx_t t;
    logic [31:0] w;
    for (int i = 0; i < 132; i++) begin
      w      = (i < 4) ? model_cnt[31:0] : regs[(i - 4) / 4];
      t.data = 8'((w >> (8 * (i % 4))) & 32'hFF);
      t.addr = (i < 4) ? 5'd0 : 5'((i - 4) / 4);
      tx_q.push_back(t);
    end
  endtask

  task automatic wait_idle(input string name, input int exp_halt_low);
    int n = 0;
    while (o_state != 3'd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, (n < 3000), 1);
    check({name, "_tx_pulses"}, tx_pulses, 132);
    check({name, "_tx_left"}, tx_q.size(), 0);
    check({name, "_halt_low"}, halt_low, exp_halt_low);
    tx_q.delete();
    have_cur = 1'b0;
  endtask

  task automatic randomize_regs();
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
  endtask

  task automatic run_test(input int n);
    randomize_regs();
    model_cnt = model_cnt + n;
    if (model_cnt > 64'hFFFF_FFFF) model_cnt = 64'hFFFF_FFFF;
    push_frame();
    halt_low = 0;
    tx_pulses = 0;
    send_byte(8'h43);
    repeat (n - 1) @(negedge clk);
    i_end_program = 1'b1;
    @(negedge clk);
    i_end_program = 1'b0;
    wait_idle("run", n);
  endtask

  task automatic step_test();
    randomize_regs();
    model_cnt = model_cnt + 1;
    push_frame();
    halt_low = 0;
    tx_pulses = 0;
    send_byte(8'h53);
    wait_idle("step", 1);
  endtask

  task automatic dump_test(input logic force_reg5);
    randomize_regs();
    if (force_reg5) regs[5] = 32'hDEAD_BEEF;
    push_frame();
    halt_low = 0;
    tx_pulses = 0;
    send_byte(8'h44);
    wait_idle("dump", 0);
  endtask

  task automatic junk_test();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'h4C || b == 8'h43 || b == 8'h53 || b == 8'h44) b = b + 8'd1;
    send_byte(b);
    check("junk_state", o_state, 0);
    repeat (3) @(negedge clk);
    check("junk_state_later", o_state, 0);
  endtask

  // Global bound on simulation time
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int choice;
    randomize_regs();
    repeat (3) @(negedge clk);
    check("init_state", o_state, 0);
    check("init_halt", o_halt, 1);
    check("init_we", o_we_IF, 0);
    check("init_tx_start", o_tx_start, 0);
    check("init_tx_data", o_tx_data, 0);
    check("init_instr", o_instruction_data, 0);
    check("init_reg_addr", o_dbg_reg_addr, 0);
    i_rst = 1'b0;

    // Load two words, the second being HALT
    load_session(1, 32'h2000_0001);
    // Single step right after a load: counter reads 1
    step_test();
    // Run for ten cycles from a fresh counter
    do_reset();
    run_test(10);
    // Dump with a known register value
    dump_test(1'b1);
    // Unknown command byte is ignored
    junk_test();
    // Reset in the middle of a word: only the fresh bytes form a word
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    load_session(1, 32'h1234_5678);

    // Random command mix
    for (int it = 0; it < 14; it++) begin
      choice = $urandom_range(0, 4);
      case (choice)
        0: load_session($urandom_range(0, 3), $urandom);
        1: run_test($urandom_range(1, 25));
        2: step_test();
        3: dump_test(1'b0);
        default: junk_test();
      endcase
    end

    repeat (5) @(negedge clk);
    check("final_we_left", we_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_controller.md
DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, meaning datapath word width.
REQ-002 SHALL have parameter NB_ADDR, default 5, meaning register-file address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_rx_data  input  8  received UART byte.
REQ-006 SHALL have port i_rx_valid  input  1  one-cycle strobe; i_rx_data valid.
REQ-007 SHALL have port i_tx_done  input  1  one-cycle strobe; transmitter finished current byte.
REQ-008 SHALL have port i_end_program  input  1  pipeline has retired the HALT word.
REQ-009 SHALL have port i_dbg_reg_data  input  NB_DATA  register-file read data for o_dbg_reg_addr, combinational.
REQ-010 SHALL have port o_tx_data  output  8  byte to transmit.
REQ-011 SHALL have port o_tx_start  output  1  one-cycle transmit request.
REQ-012 SHALL have port o_we_IF  output  1  one-cycle instruction-memory write strobe.
REQ-013 SHALL have port o_instruction_data  output  NB_DATA  instruction word to write.
REQ-014 SHALL have port o_halt  output  1  pipeline freeze; 1 = frozen.
REQ-015 SHALL have port o_dbg_reg_addr  output  NB_ADDR  register selected for dump.
REQ-016 SHALL have port o_state  output  3  current FSM state encoding, for debug.

Function
REQ-017 SHALL implement states IDLE=0, LOAD=1, RUN=2, STEP=3, DUMP_REQ=4, DUMP_WAIT=5.
REQ-018 SHALL decode commands only in IDLE, on i_rx_valid: 0x4C 'L' -> LOAD, clears cycle counter; 0x43 'C' -> RUN; 0x53 'S' -> STEP; 0x44 'D' -> DUMP_REQ; any other byte ignored, stays IDLE.
REQ-019 SHALL ignore i_rx_valid in RUN, STEP, DUMP_REQ, DUMP_WAIT.
REQ-020 SHALL, in LOAD, assemble words LSB-first from 4 consecutive received bytes via a 2-bit byte counter wrapping 3->0.
REQ-021 SHALL, on the 4th byte, pulse o_we_IF for exactly one cycle on the next clock, with o_instruction_data holding the assembled word during that cycle.
REQ-022 SHALL, when the assembled word equals 0xFFFFFFFF (HALT), write it as per REQ-021 and then return to IDLE.
REQ-023 SHALL drive o_halt=1 in every state except RUN, and drive o_halt=0 for exactly one cycle in STEP.
REQ-024 SHALL, in STEP, spend exactly one cycle, then go to DUMP_REQ.
REQ-025 SHALL, in RUN, go to DUMP_REQ on the cycle after i_end_program=1; o_halt SHALL be 1 from that transition on.
REQ-026 SHALL increment a NB_DATA-bit cycle counter each cycle o_halt=0, saturating at 0xFFFFFFFF.
REQ-027 SHALL dump a 132-byte frame: cycle counter (4 bytes), then registers 0..31 (4 bytes each), every word LSB-first.
REQ-028 SHALL, in DUMP_REQ, set o_tx_data to the current byte, pulse o_tx_start for one cycle, and go to DUMP_WAIT.
REQ-029 SHALL hold o_tx_data and o_dbg_reg_addr stable in DUMP_WAIT until i_tx_done.
REQ-030 SHALL, on i_tx_done, advance the byte index (0..131) and return to DUMP_REQ; after byte 131, go to IDLE.
REQ-031 SHALL set o_dbg_reg_addr = (byte_index-4)>>2 for byte_index >= 4, and 0 otherwise.
REQ-032 SHALL ignore i_tx_done outside DUMP_WAIT and i_end_program outside RUN.

Reset
REQ-033 SHALL, when i_rst=1 at a clock edge, regardless of state (including mid-load or mid-dump), set state=IDLE, o_halt=1, o_we_IF=0, o_tx_start=0, o_tx_data=0, o_instruction_data=0, o_dbg_reg_addr=0, byte counter=0, byte index=0, cycle counter=0.
REQ-034 SHALL discard any partially assembled word and any partially sent frame on reset.

Verification
REQ-035 SHALL verify load: 'L', 0x01,0x00,0x00,0x20, then FF,FF,FF,FF -> two o_we_IF pulses with words 0x20000001 and 0xFFFFFFFF, then state IDLE.
REQ-036 SHALL verify run: 'C', i_end_program after 10 cycles -> o_halt low exactly 10 cycles, frame starts 0x0A,0x00,0x00,0x00.
REQ-037 SHALL verify step: 'S' after 'L' -> o_halt low exactly 1 cycle, frame bytes 0..3 = 0x01,0x00,0x00,0x00, 132 o_tx_start pulses total.
REQ-038 SHALL verify dump: 'D' with reg5=0xDEADBEEF -> bytes 24..27 = EF,BE,AD,DE, with o_dbg_reg_addr=5 during them.
REQ-039 SHALL verify robustness: byte 0x7A in IDLE -> no state change; i_rst asserted after the 2nd load byte, then 'L' plus 4 bytes -> exactly one write, containing only the new bytes.
